// File: rtl/robot_frame_if.sv
// Handshake bundle between the robot frame scheduler and its neighbours
// (gamepad, VGA timing, robot FSM, map block, cursor editor).
`timescale 1ns/1ps
interface robot_frame_if;
    logic       v_sync;
    logic       auto_toggle;
    logic       step_req;
    logic       edit_req;
    logic       robot_cmd_valid;
    logic [1:0] robot_cmd;
    logic       map_done;
    logic       robot_tick;
    logic       map_cmd_valid;
    logic [1:0] map_cmd;
    logic       map_src;
    logic       edit_grant;
    logic       sensor_latch;
    logic       auto_mode;
    logic       err_timeout;

    modport master (
        output v_sync, auto_toggle, step_req, edit_req, robot_cmd_valid, robot_cmd, map_done,
        input  robot_tick, map_cmd_valid, map_cmd, map_src, edit_grant, sensor_latch,
               auto_mode, err_timeout
    );

    modport slave (
        input  v_sync, auto_toggle, step_req, edit_req, robot_cmd_valid, robot_cmd, map_done,
        output robot_tick, map_cmd_valid, map_cmd, map_src, edit_grant, sensor_latch,
               auto_mode, err_timeout
    );
endinterface

// File: rtl/robot_frame_scheduler.sv
// Robot step sequencer: generates robot ticks (auto or manual), captures the robot
// command and arbitrates frame-aligned map writes between the robot and the editor.
`timescale 1ns/1ps
module robot_frame_scheduler #(
    parameter int AUTO_PERIOD = 30,
    parameter int PERIOD_W    = 6,
    parameter int TIMEOUT     = 15
) (
    input logic          clock,
    input logic          reset,
    robot_frame_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        TICK,
        WAIT_CMD,
        WAIT_FRAME,
        APPLY,
        LATCH
    } state_t;

    localparam logic [PERIOD_W-1:0] LAST_FRAME = PERIOD_W'(AUTO_PERIOD - 1);
    localparam logic [7:0]          LAST_WAIT  = 8'(TIMEOUT - 1);

    state_t              state_q;
    logic                v_sync_q;
    logic                auto_toggle_q;
    logic                step_req_q;
    logic [PERIOD_W-1:0] frame_cnt_q;
    logic [PERIOD_W-1:0] frame_cnt_d;
    logic                step_pend_q;
    logic                step_pend_d;
    logic [7:0]          wait_cnt_q;
    logic [1:0]          cmd_q;
    logic                robot_tick_q;
    logic                map_cmd_valid_q;
    logic [1:0]          map_cmd_q;
    logic                map_src_q;
    logic                edit_grant_q;
    logic                sensor_latch_q;
    logic                auto_mode_q;
    logic                err_timeout_q;

    logic frame_pulse;
    logic toggle_edge;
    logic step_edge;
    logic edit_win;

    assign frame_pulse = bus.v_sync & ~v_sync_q;
    assign toggle_edge = bus.auto_toggle & ~auto_toggle_q;
    assign step_edge   = bus.step_req & ~step_req_q;
    assign edit_win    = (state_q == IDLE) && bus.edit_req && frame_pulse;

    // Step generation; a pending step survives mode toggles and editor frames.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        step_pend_d = step_pend_q;
        if (auto_mode_q && frame_pulse) begin
            if (frame_cnt_q == LAST_FRAME) begin
                frame_cnt_d = '0;
                step_pend_d = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + PERIOD_W'(1);
            end
        end
        if (toggle_edge) begin
            frame_cnt_d = '0;
        end
        if (!auto_mode_q && step_edge) begin
            step_pend_d = 1'b1;
        end
        if ((state_q == IDLE) && !edit_win && step_pend_q) begin
            step_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            v_sync_q        <= 1'b0;
            auto_toggle_q   <= 1'b0;
            step_req_q      <= 1'b0;
            frame_cnt_q     <= '0;
            step_pend_q     <= 1'b0;
            robot_tick_q    <= 1'b0;
            map_cmd_valid_q <= 1'b0;
            map_cmd_q       <= 2'b00;
            map_src_q       <= 1'b0;
            edit_grant_q    <= 1'b0;
            sensor_latch_q  <= 1'b0;
            auto_mode_q     <= 1'b0;
            err_timeout_q   <= 1'b0;
        end else begin
            v_sync_q       <= bus.v_sync;
            auto_toggle_q  <= bus.auto_toggle;
            step_req_q     <= bus.step_req;
            auto_mode_q    <= auto_mode_q ^ toggle_edge;
            frame_cnt_q    <= frame_cnt_d;
            step_pend_q    <= step_pend_d;
            robot_tick_q   <= 1'b0;
            edit_grant_q   <= 1'b0;
            sensor_latch_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (edit_win) begin
                        state_q         <= APPLY;
                        map_src_q       <= 1'b1;
                        map_cmd_q       <= 2'b00;
                        map_cmd_valid_q <= 1'b1;
                        edit_grant_q    <= 1'b1;
                    end else if (step_pend_q) begin
                        state_q      <= TICK;
                        robot_tick_q <= 1'b1;
                    end
                end
                TICK: begin
                    state_q    <= WAIT_CMD;
                    wait_cnt_q <= 8'd0;
                end
                WAIT_CMD: begin
                    if (bus.robot_cmd_valid) begin
                        cmd_q   <= bus.robot_cmd;
                        state_q <= (bus.robot_cmd == 2'b00) ? IDLE : WAIT_FRAME;
                    end else if (wait_cnt_q == LAST_WAIT) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                WAIT_FRAME: begin
                    // Robot owns this frame edge even if the editor is also asking.
                    if (frame_pulse) begin
                        state_q         <= APPLY;
                        map_src_q       <= 1'b0;
                        map_cmd_q       <= cmd_q;
                        map_cmd_valid_q <= 1'b1;
                    end
                end
                APPLY: begin
                    if (bus.map_done) begin
                        state_q         <= LATCH;
                        map_cmd_valid_q <= 1'b0;
                        sensor_latch_q  <= 1'b1;
                    end
                end
                LATCH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.robot_tick    = robot_tick_q;
    assign bus.map_cmd_valid = map_cmd_valid_q;
    assign bus.map_cmd       = map_cmd_q;
    assign bus.map_src       = map_src_q;
    assign bus.edit_grant    = edit_grant_q;
    assign bus.sensor_latch  = sensor_latch_q;
    assign bus.auto_mode     = auto_mode_q;
    assign bus.err_timeout   = err_timeout_q;

endmodule
